// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin regfile write-port arbiter with busy scoreboard
module regfile_write_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*5-1:0]    req_addr_i,
  input  logic [NUM_REQ*32-1:0]   req_data_i,
  input  logic                    claim_valid_i,
  input  logic [4:0]              claim_addr_i,
  input  logic                    flush_i,
  output logic [31:0]             busy_o,
  output logic                    write_enable_o,
  output logic [4:0]              write_addr_o,
  output logic [31:0]             write_data_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               gnt_found;
  logic [PTR_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [4:0]         sel_addr;
  logic [31:0]        sel_data;

  logic               we_q, we_d;
  logic [4:0]         waddr_q, waddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        busy_q, busy_d;

  // Scan from rr_ptr_q with wrap-around; first valid requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(idx);
        sel_addr  = req_addr_i[idx*5 +: 5];
        sel_data  = req_data_i[idx*32 +: 32];
      end
    end
    if (gnt_found) gnt_oh[gnt_idx] = 1'b1;
  end

  assign req_ready_o = rst_ni ? gnt_oh : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_found) begin
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  // x0 transfers are accepted but never reach the port.
  always_comb begin
    we_d    = gnt_found && (sel_addr != 5'd0);
    waddr_d = we_d ? sel_addr : waddr_q;
    wdata_d = we_d ? sel_data : wdata_q;
  end

  // A claim in the commit cycle wins: a newer producer owns the register.
  always_comb begin
    busy_d = '0;
    for (int r = 1; r < 32; r++) begin
      if (!flush_i) begin
        busy_d[r] = (claim_valid_i && claim_addr_i == 5'(r))
                  | (busy_q[r] & ~(we_q && waddr_q == 5'(r)));
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o         = busy_q;
  assign write_enable_o = we_q;
  assign write_addr_o   = waddr_q;
  assign write_data_o   = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*5-1:0] req_addr;
  logic [N*32-1:0] req_data;
  logic           claim_valid;
  logic [4:0]     claim_addr;
  logic           flush;
  logic [31:0]    busy;
  logic           we;
  logic [4:0]     waddr;
  logic [31:0]    wdata;

  int checks = 0;
  int errors = 0;

  // reference model state
  int        m_ptr;
  bit        m_we;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  bit        m_busy [32];

  regfile_write_arbiter #(.NUM_REQ(N)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .claim_valid_i(claim_valid), .claim_addr_i(claim_addr), .flush_i(flush),
    .busy_o(busy), .write_enable_o(we), .write_addr_o(waddr), .write_data_o(wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input bit [4:0] a, input bit [31:0] d);
    req_valid[i]        = v;
    req_addr[i*5 +: 5]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit [31:0] model_busy_vec();
    bit [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_we = 0; m_addr = 0; m_data = 0;
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
  endtask

  task automatic model_edge(input int g);
    bit nb [32];
    bit [4:0] a;
    for (int r = 0; r < 32; r++) begin
      if (flush) nb[r] = 0;
      else if (claim_valid && claim_addr == r && r != 0) nb[r] = 1;
      else if (m_we && m_addr == r) nb[r] = 0;
      else nb[r] = m_busy[r];
    end
    for (int r = 0; r < 32; r++) m_busy[r] = nb[r];
    m_we = 0;
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      a = req_addr[g*5 +: 5];
      if (a != 0) begin
        m_we = 1; m_addr = a; m_data = req_data[g*32 +: 32];
      end
    end
  endtask

  task automatic test_reset();
    set_req(0, 1, 5'd4, 32'h0000_1111);
    claim_valid = 1; claim_addr = 5'd10;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_pre_ready got %b want 01", req_ready); end
    tick();
    claim_valid = 0;
    set_req(1, 1, 5'd6, 32'h0000_2222);
    checks++; if (we !== 1'b1 || busy[10] !== 1'b1) begin errors++; $display("FAIL reset_pre_state we=%b busy=%h want we=1 busy[10]=1", we, busy); end
    #2;
    rst_n = 0;
    #1;
    checks++; if (we !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0) begin errors++; $display("FAIL reset_port we=%b addr=%0d data=%h want 0", we, waddr, wdata); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
    tick();
    rst_n = 1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b want 01", req_ready); end
    set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
    tick();
  endtask

  task automatic test_single_write();
    set_req(0, 1, 5'd5, 32'hDEADBEEF);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", req_ready); end
    tick();
    set_req(0, 0, 0, 0);
    checks++; if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_write we=%b addr=%0d data=%h want 1/5/deadbeef", we, waddr, wdata); end
    tick();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL single_idle we=%b want 0", we); end
  endtask

  task automatic test_x0_write();
    set_req(1, 1, 5'd0, 32'hFFFFFFFF);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL x0_ready got %b want 10", req_ready); end
    tick();
    set_req(1, 0, 0, 0);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL x0_dropped we=%b want 0", we); end
    set_req(0, 1, 5'd3, 32'h3); set_req(1, 1, 5'd4, 32'h4);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL x0_ptr_advance got %b want 01", req_ready); end
    set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
    tick();
  endtask

  task automatic test_round_robin();
    bit [1:0] exp_rdy;
    bit [4:0] exp_a;
    set_req(0, 1, 5'd1, 32'hA1A1_0001);
    set_req(1, 1, 5'd2, 32'hB2B2_0002);
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, exp_rdy); end
      tick();
      if (k == 3) begin set_req(0, 0, 0, 0); set_req(1, 0, 0, 0); end
      exp_a = (k % 2 == 0) ? 5'd1 : 5'd2;
      checks++; if (we !== 1'b1 || waddr !== exp_a) begin errors++; $display("FAIL rr_write%0d we=%b addr=%0d want 1/%0d", k, we, waddr, exp_a); end
    end
    tick();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rr_idle we=%b want 0", we); end
  endtask

  task automatic test_scoreboard();
    claim_valid = 1; claim_addr = 5'd7;
    tick();
    claim_valid = 0;
    checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL sb_claimed busy=%h want bit7", busy); end
    tick();
    set_req(0, 1, 5'd7, 32'h7777_0007);
    #1;
    checks++; if (req_ready !== 2'b01 || busy[7] !== 1'b1) begin errors++; $display("FAIL sb_xfer ready=%b busy=%h", req_ready, busy); end
    tick();
    set_req(0, 0, 0, 0);
    checks++; if (we !== 1'b1 || waddr !== 5'd7 || busy[7] !== 1'b1) begin errors++; $display("FAIL sb_commit we=%b addr=%0d busy=%h", we, waddr, busy); end
    tick();
    checks++; if (busy[7] !== 1'b0) begin errors++; $display("FAIL sb_released busy=%h want bit7 clear", busy); end
    claim_valid = 1; claim_addr = 5'd7;
    tick();
    claim_valid = 0;
    tick();
    set_req(0, 1, 5'd7, 32'h7777_0008);
    tick();
    set_req(0, 0, 0, 0);
    claim_valid = 1; claim_addr = 5'd7;
    checks++; if (we !== 1'b1 || waddr !== 5'd7) begin errors++; $display("FAIL sb_commit2 we=%b addr=%0d", we, waddr); end
    tick();
    claim_valid = 0;
    checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL sb_set_wins busy=%h want bit7", busy); end
  endtask

  task automatic test_flush();
    flush = 1;
    tick();
    flush = 0;
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL flush_clear got %h want 0", busy); end
    for (int r = 8; r < 12; r++) begin
      claim_valid = 1; claim_addr = 5'(r);
      if (r == 11) set_req(0, 1, 5'd9, 32'h9999_0001);
      tick();
    end
    claim_valid = 0;
    set_req(0, 0, 0, 0);
    checks++; if (busy !== 32'h0000_0F00 || we !== 1'b1 || waddr !== 5'd9) begin errors++; $display("FAIL flush_setup busy=%h we=%b addr=%0d want 00000f00/1/9", busy, we, waddr); end
    flush = 1; claim_valid = 1; claim_addr = 5'd3;
    set_req(1, 1, 5'd9, 32'h9999_0002);
    tick();
    flush = 0; claim_valid = 0;
    set_req(1, 0, 0, 0);
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL flush_wins got %h want 0", busy); end
    checks++; if (we !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h9999_0002) begin errors++; $display("FAIL flush_keeps_write we=%b addr=%0d data=%h", we, waddr, wdata); end
    tick();
  endtask

  task automatic test_random();
    bit pending [N];
    int g;
    rst_n = 0;
    #1;
    rst_n = 1;
    model_reset();
    for (int i = 0; i < N; i++) pending[i] = 0;
    tick();
    for (int c = 0; c < 400; c++) begin
      checks++; if (we !== m_we) begin errors++; $display("FAIL rnd_we c=%0d got %b want %b", c, we, m_we); end
      if (m_we) begin
        checks++; if (waddr !== m_addr || wdata !== m_data) begin errors++; $display("FAIL rnd_port c=%0d got %0d/%h want %0d/%h", c, waddr, wdata, m_addr, m_data); end
      end
      checks++; if (busy !== model_busy_vec()) begin errors++; $display("FAIL rnd_busy c=%0d got %h want %h", c, busy, model_busy_vec()); end
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(0, 1) == 1) begin
          pending[i] = 1;
          set_req(i, 1, 5'($urandom_range(0, 12)), $urandom);
        end
        req_valid[i] = pending[i];
      end
      claim_valid = ($urandom_range(0, 2) == 0);
      claim_addr  = 5'($urandom_range(0, 12));
      flush       = ($urandom_range(0, 19) == 0);
      #1;
      g = model_grant();
      checks++; if (req_ready !== ((g < 0) ? 2'b00 : 2'(1 << g))) begin errors++; $display("FAIL rnd_ready c=%0d got %b want grant %0d", c, req_ready, g); end
      model_edge(g);
      if (g >= 0) pending[g] = 0;
      tick();
    end
    set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
    claim_valid = 0; flush = 0;
  endtask

  initial begin
    rst_n = 0;
    req_valid = '0; req_addr = '0; req_data = '0;
    claim_valid = 0; claim_addr = '0; flush = 0;
    tick(); tick();
    rst_n = 1;
    tick();
    test_reset();
    test_single_write();
    test_x0_write();
    test_round_robin();
    test_scoreboard();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
